pwm_audio_dac: RTL and testbench
================================

// Module: pwm_audio_dac
// PURPOSE
//  Output stage that sits directly downstream of the square-wave generator.
//  It takes the generator's 8-bit sample (square_out) as sample_in and scales it
//  by an attack/sustain/release volume envelope driven by a note gate.
//  It then converts the scaled sample to a 1-bit PWM stream for the board's
//  speaker/RC filter pin.
// PARAMETERS
//  PRESCALE      1   clocks per PWM counter step (>=1); frame = 256*PRESCALE clocks
//  ATTACK_STEP   16  envelope increment per frame in ATTACK (1..255)
//  RELEASE_STEP  8   envelope decrement per frame in RELEASE (1..255)
// PORTS
//  clk           in   1  system clock
//  reset         in   1  synchronous, active-high reset
//  sample_in     in   8  unsigned sample from square_wave.square_out
//  gate          in   1  note on (1) / note off (0)
//  pwm_out       out  1  registered PWM (or sigma-delta) audio bit
//  frame_tick    out  1  one-clock pulse on the clock that ends each frame
//  env_level     out  8  current envelope level
//  env_busy      out  1  1 when the envelope state is not IDLE
// BEHAVIOUR
//  - Interface: one clock (clk); reset is synchronous and active-high (reset).
//  - On reset: pwm_out=0, frame_tick=0, env_level=0, env_busy=0, state=IDLE,
//    and the prescale counter, PWM counter cnt[7:0] and duty are all 0.
//  - Prescaler: step=1 when the prescale counter reaches PRESCALE-1; it then wraps to 0.
//    cnt increments on each step and wraps 255->0.
//  - Frame end: step && cnt==255. On that clock:
//    - frame_tick=1 (next cycle, registered);
//    - duty <= (sample_in*env_level)>>8, a 16-bit product with the upper byte kept,
//      so 255*255 gives 254;
//    - the envelope updates.
//  - sample_in is sampled only at frame end. The new duty takes effect from cnt==0
//    of the next frame.
//  - pwm_out <= (cnt < duty), registered, so there is 1 clk latency from cnt.
//    - duty=0 keeps pwm_out low for the whole frame.
//    - duty=254 gives 254/256 high.
//  - Envelope FSM (states IDLE, ATTACK, SUSTAIN, RELEASE). It is evaluated only at
//    frame end, and gate is sampled there.
//    - IDLE: gate=1 -> ATTACK; otherwise level stays 0.
//    - ATTACK: gate=0 -> RELEASE.
//      Otherwise level += ATTACK_STEP, saturating at 255.
//      Reaching 255 -> SUSTAIN.
//    - SUSTAIN: level=255; gate=0 -> RELEASE.
//    - RELEASE: gate=1 -> ATTACK, continuing from the current level with no reset to 0.
//      Otherwise level -= RELEASE_STEP, flooring at 0.
//      Reaching 0 -> IDLE.
//    - Gate pulses shorter than one frame and falling before frame end are ignored.
//  - env_busy = (state != IDLE), registered together with the state.
//  - Reset mid-frame or mid-envelope: everything returns to reset values on the
//    next edge, and the new frame starts at cnt=0.
//  - reset has priority over all other events in the same cycle.
// CONFIGURATION
//  SIGMA_DELTA_EN defined:
//    - pwm_out comes from a first-order sigma-delta modulator instead.
//    - Every clk: acc[8:0] <= acc[7:0] + duty; pwm_out <= acc[8] (the carry).
//    - acc resets to 0.
//    - Frame timing, duty latching and the envelope are unchanged.
//    - Ones-density over 256 clks = duty/256.
//  Not defined: comparator PWM as above, and no acc register exists.
// TESTING
//  1. Reset for 2 clks with gate=0, sample_in=8'hFF -> pwm_out=0, env_level=0,
//     env_busy=0, frame_tick=0 throughout 3 frames.
//  2. PRESCALE=1, gate=1 from reset release -> env_level=16,32,...,240 then 255 at
//     the 16th frame end; state SUSTAIN; env_busy=1.
//  3. SUSTAIN, sample_in=8'hFF -> from the next frame pwm_out is high for exactly
//     254 of 256 clks; sample_in=0 -> 0 of 256.
//  4. gate drops in SUSTAIN -> level 247,239,...,7 then 0 at the 32nd frame;
//     env_busy falls at that frame end.
//  5. gate re-asserted in RELEASE at level 127 -> the next frame gives 143, with no
//     dip to 0.
//  6. reset asserted mid-frame at cnt=100 in SUSTAIN -> all outputs back to reset
//     values on the next edge; a frame_tick is seen exactly 256 clks after reset
//     release.

Source files
------------

// File: rtl/pwm_audio_dac.sv
// -----------------------------------------------------------------------------
// pwm_audio_dac
//   Audio output stage placed after the square-wave generator. The 8-bit sample
//   is scaled by an attack/sustain/release envelope that follows a note gate.
//   The scaled value is then turned into a 1-bit PWM stream for the speaker or
//   RC filter pin.
//
//   A frame is 256 PWM counter steps, and one step is PRESCALE clocks. The
//   envelope, the sample and the duty value are only updated on the last clock
//   of each frame.
//
// Parameters
//   PRESCALE      clocks per PWM counter step (>=1)
//   ATTACK_STEP   envelope increment per frame while attacking (1..255)
//   RELEASE_STEP  envelope decrement per frame while releasing (1..255)
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   sample_in   unsigned 8-bit sample (square_wave.square_out)
//   gate        note on (1) / note off (0), sampled at frame end
//   pwm_out     registered PWM (or sigma-delta) audio bit
//   frame_tick  one-clock pulse following the last clock of each frame
//   env_level   current envelope level
//   env_busy    1 while the envelope is not IDLE
//
// Build option
//   SIGMA_DELTA_EN  when defined, pwm_out comes from a first-order sigma-delta
//                   modulator driven by duty instead of the PWM comparator.
// -----------------------------------------------------------------------------
module pwm_audio_dac #(
  parameter int PRESCALE     = 1,
  parameter int ATTACK_STEP  = 16,
  parameter int RELEASE_STEP = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sample_in,
  input  logic       gate,
  output logic       pwm_out,
  output logic       frame_tick,
  output logic [7:0] env_level,
  output logic       env_busy
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  typedef enum logic [1:0] {IDLE, ATTACK, SUSTAIN, RELEASE} env_state_t;

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic logic [7:0] sat_sub(input logic [7:0] a, input logic [7:0] b);
    return (b >= a) ? 8'h00 : (a - b);
  endfunction

  // Upper byte of the 16-bit product, so full scale times full scale gives 254.
  function automatic logic [7:0] scale(input logic [7:0] s, input logic [7:0] l);
    logic [15:0] p;
    p = 16'(s) * 16'(l);
    return p[15:8];
  endfunction

  logic [PW-1:0] presc_cnt;
  logic [7:0]    cnt;
  logic [7:0]    duty;
  env_state_t    state;
  env_state_t    state_nxt;
  logic [7:0]    level_nxt;
  logic          step_p0;
  logic          frame_end_p0;

  // Stage p0: step and frame-end decode from the counters
  assign step_p0      = (presc_cnt == PW'(PRESCALE - 1));
  assign frame_end_p0 = step_p0 && (cnt == 8'hFF);

  // Transitions apply the destination state's level action on the same frame
  // end. That way a re-gate during release keeps climbing from the current
  // level and never drops back to 0.
  always_comb begin
    env_state_t tgt;
    tgt       = state;
    state_nxt = state;
    level_nxt = env_level;
    case (state)
      IDLE:    tgt = gate ? ATTACK  : IDLE;
      ATTACK:  tgt = gate ? ATTACK  : RELEASE;
      SUSTAIN: tgt = gate ? SUSTAIN : RELEASE;
      RELEASE: tgt = gate ? ATTACK  : RELEASE;
      default: tgt = IDLE;
    endcase
    case (tgt)
      ATTACK: begin
        level_nxt = sat_add(env_level, 8'(ATTACK_STEP));
        state_nxt = (level_nxt == 8'hFF) ? SUSTAIN : ATTACK;
      end
      RELEASE: begin
        level_nxt = sat_sub(env_level, 8'(RELEASE_STEP));
        state_nxt = (level_nxt == 8'h00) ? IDLE : RELEASE;
      end
      SUSTAIN: begin
        level_nxt = 8'hFF;
        state_nxt = SUSTAIN;
      end
      default: begin
        level_nxt = 8'h00;
        state_nxt = IDLE;
      end
    endcase
  end

  // Stage p1: counters, frame tick, duty latch and envelope registers
  always_ff @(posedge clk) begin
    if (reset) begin
      presc_cnt  <= '0;
      cnt        <= '0;
      duty       <= '0;
      frame_tick <= 1'b0;
      state      <= IDLE;
      env_level  <= '0;
      env_busy   <= 1'b0;
    end else begin
      frame_tick <= frame_end_p0;
      if (step_p0) begin
        presc_cnt <= '0;
        cnt       <= cnt + 8'd1;
      end else begin
        presc_cnt <= presc_cnt + PW'(1);
      end
      if (frame_end_p0) begin
        duty      <= scale(sample_in, env_level);
        state     <= state_nxt;
        env_level <= level_nxt;
        env_busy  <= (state_nxt != IDLE);
      end
    end
  end

`ifdef SIGMA_DELTA_EN
  logic [8:0] acc;

  // Stage p2: first-order sigma-delta, the carry out is the audio bit
  always_ff @(posedge clk) begin
    if (reset) begin
      acc     <= '0;
      pwm_out <= 1'b0;
    end else begin
      acc     <= {1'b0, acc[7:0]} + {1'b0, duty};
      pwm_out <= acc[8];
    end
  end
`else
  // Stage p2: comparator PWM, one clock behind cnt
  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_out <= 1'b0;
    end else begin
      pwm_out <= (cnt < duty);
    end
  end
`endif

endmodule

// File: tb/tb_pwm_audio_dac.sv
module tb_pwm_audio_dac;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] sample_in;
  logic       gate;
  logic       pwm_out;
  logic       frame_tick;
  logic [7:0] env_level;
  logic       env_busy;

  always #5 clk = ~clk;

  pwm_audio_dac #(
    .PRESCALE    (1),
    .ATTACK_STEP (16),
    .RELEASE_STEP(8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sample_in (sample_in),
    .gate      (gate),
    .pwm_out   (pwm_out),
    .frame_tick(frame_tick),
    .env_level (env_level),
    .env_busy  (env_busy)
  );

  typedef struct {
    logic [7:0] lvl;
    logic       busy;
    int         pwm_cnt;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   duty_track;
  int   lvl_track;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: counts pwm_out highs per frame; on each frame_tick it pops the
  // expectation queued by the stimulus side and compares.
  initial begin
    int   hi;
    exp_t e;
    hi = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hi = 0;
      end else begin
        if (pwm_out === 1'b1) hi++;
        if (frame_tick === 1'b1) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_tick: frame_tick with no expectation queued at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("env_level", env_level, e.lvl);
            check("env_busy", env_busy, e.busy);
            check("pwm_high_count", hi, e.pwm_cnt);
          end
          hi = 0;
        end
      end
    end
  end

  task automatic wait_tick();
    bit seen;
    seen = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clk);
      if (frame_tick === 1'b1) seen = 1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL frame_tick_timeout: got none expected one within 300 clks");
    end
  endtask

  // Issue one frame: drive inputs, queue the expected frame-end response
  // (level after this frame end, busy, and pwm highs from the duty latched at
  // the previous frame end), then wait for the frame to finish.
  task automatic do_frame(input logic g, input logic [7:0] s, input int exp_lvl,
                          input logic exp_busy, input bit pulse);
    exp_t e;
    gate      = g;
    sample_in = s;
    e.lvl     = exp_lvl[7:0];
    e.busy    = exp_busy;
    e.pwm_cnt = duty_track;
    exp_q.push_back(e);
    duty_track = (int'(s) * lvl_track) >> 8;
    lvl_track  = exp_lvl;
    if (pulse) begin
      repeat (50) @(negedge clk);
      gate = 1'b1;
      repeat (10) @(negedge clk);
      gate = 1'b0;
    end
    wait_tick();
  endtask

  initial begin
    int   n;
    bit   seen;
    exp_t e;
    logic [7:0] sus_s [5];
    sus_s = '{8'hFF, 8'hFF, 8'h80, 8'h00, 8'h00};

    reset      = 1'b1;
    gate       = 1'b0;
    sample_in  = 8'hFF;
    duty_track = 0;
    lvl_track  = 0;

    // Reset state
    repeat (2) begin
      @(negedge clk);
      check("rst_pwm_out", pwm_out, 0);
      check("rst_frame_tick", frame_tick, 0);
      check("rst_env_level", env_level, 0);
      check("rst_env_busy", env_busy, 0);
    end
    reset = 1'b0;

    // Idle frames, the last with a short gate pulse that must be ignored
    do_frame(1'b0, 8'hFF, 0, 1'b0, 1'b0);
    do_frame(1'b0, 8'hFF, 0, 1'b0, 1'b0);
    do_frame(1'b0, 8'hFF, 0, 1'b0, 1'b1);

    // Attack 16, 32, ... 240, then 255 on the 16th frame
    for (int k = 1; k <= 16; k++)
      do_frame(1'b1, 8'hFF, (k < 16) ? 16 * k : 255, 1'b1, 1'b0);

    // Sustain with several samples: counts 239, 254, 254, 127, 0
    for (int k = 0; k < 5; k++)
      do_frame(1'b1, sus_s[k], 255, 1'b1, 1'b0);

    // Full release 247 ... 7, then 0 and IDLE on the 32nd frame
    for (int k = 1; k <= 32; k++)
      do_frame(1'b0, 8'hFF, (k < 32) ? 255 - 8 * k : 0, (k < 32), 1'b0);
    do_frame(1'b0, 8'hFF, 0, 1'b0, 1'b0);

    // Attack again, release to 127, re-gate to 143 and on to sustain
    for (int k = 1; k <= 16; k++)
      do_frame(1'b1, 8'h40, (k < 16) ? 16 * k : 255, 1'b1, 1'b0);
    for (int k = 1; k <= 16; k++)
      do_frame(1'b0, 8'hC0, 255 - 8 * k, 1'b1, 1'b0);
    do_frame(1'b1, 8'hFF, 143, 1'b1, 1'b0);
    for (int k = 1; k <= 7; k++)
      do_frame(1'b1, 8'hFF, 143 + 16 * k, 1'b1, 1'b0);
    do_frame(1'b1, 8'hFF, 255, 1'b1, 1'b0);

    // Reset in sustain at cnt==100
    repeat (100) @(negedge clk);
    reset = 1'b1;
    gate  = 1'b0;
    @(negedge clk);
    check("midrst_pwm_out", pwm_out, 0);
    check("midrst_frame_tick", frame_tick, 0);
    check("midrst_env_level", env_level, 0);
    check("midrst_env_busy", env_busy, 0);
    @(negedge clk);
    reset      = 1'b0;
    duty_track = 0;
    lvl_track  = 0;
    e.lvl      = 8'h00;
    e.busy     = 1'b0;
    e.pwm_cnt  = 0;
    exp_q.push_back(e);
    n    = 0;
    seen = 0;
    while (n < 300 && !seen) begin
      @(negedge clk);
      n++;
      if (frame_tick === 1'b1) seen = 1;
    end
    check("tick_after_reset_clks", n, 256);
    check("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
